// File: rtl/gray_monitor.sv
// gray_monitor: watches a 3-bit Gray counter stream, decodes it to binary,
// flags illegal steps, counts errors and 7->0 wraps, and cross-checks the
// upstream sticky overflow flag against the wraps it has actually seen.
module gray_monitor (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Valid,
  input  logic [2:0] GrayIn,
  input  logic       OverflowIn,
  output logic [2:0] Binary,
  output logic       StepErr,
  output logic [7:0] ErrCount,
  output logic [7:0] WrapCount,
  output logic       OvfMismatch,
  output logic       Locked,
  output logic [1:0] State
);

  // S_BAD is listed so the unused encoding is representable and recoverable.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_TRACK = 2'b01,
    S_ERR   = 2'b10,
    S_BAD   = 2'b11
  } state_t;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [2:0] gray2bin(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    b[1] = g[2] ^ g[1];
    b[0] = g[2] ^ g[1] ^ g[0];
    return b;
  endfunction

  // Error counter increments but never rolls over.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t     r_state;
  logic [2:0] r_prev;
  logic       r_step_err;
  logic [7:0] r_err_cnt;
  logic [7:0] r_wrap_cnt;
  logic       r_ovf_mis;
  logic       r_wrap_seen;

  state_t     w_state_nxt;
  logic [2:0] w_prev_nxt;
  logic       w_step_err_nxt;
  logic [7:0] w_err_cnt_nxt;
  logic [7:0] w_wrap_cnt_nxt;
  logic       w_ovf_mis_nxt;
  logic       w_wrap_seen_nxt;

  logic [2:0] w_bin;
  logic [2:0] w_prev_inc;
  logic       w_hold;
  logic       w_step;
  logic       w_wrap;
  logic       w_exp_ovf;

  // Classify the decoded sample against the last captured value.
  always_comb begin
    w_bin      = gray2bin(GrayIn);
    w_prev_inc = r_prev + 3'd1;
    w_hold     = (w_bin == r_prev);
    w_step     = (w_bin == w_prev_inc);
    w_wrap     = w_step && (r_prev == 3'd7);
    w_exp_ovf  = r_wrap_seen | w_wrap;
  end

  // Next-state and next-value logic; StepErr defaults low so it only pulses.
  always_comb begin
    w_state_nxt     = r_state;
    w_prev_nxt      = r_prev;
    w_step_err_nxt  = 1'b0;
    w_err_cnt_nxt   = r_err_cnt;
    w_wrap_cnt_nxt  = r_wrap_cnt;
    w_ovf_mis_nxt   = r_ovf_mis;
    w_wrap_seen_nxt = r_wrap_seen;
    case (r_state)
      S_IDLE: begin
        if (Valid) begin
          w_prev_nxt  = w_bin;
          w_state_nxt = S_TRACK;
        end
      end
      S_TRACK, S_ERR: begin
        if (Valid) begin
          w_prev_nxt = w_bin;
          if (w_hold || w_step) begin
            w_state_nxt = S_TRACK;
            if (w_wrap) begin
              w_wrap_cnt_nxt  = r_wrap_cnt + 8'd1;
              w_wrap_seen_nxt = 1'b1;
            end
          end else begin
            w_state_nxt    = S_ERR;
            w_step_err_nxt = 1'b1;
            w_err_cnt_nxt  = sat_inc8(r_err_cnt);
          end
          // Overflow is only trusted while locked; ERR samples are skipped.
          if ((r_state == S_TRACK) && (OverflowIn != w_exp_ovf))
            w_ovf_mis_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and counter registers with asynchronous clear.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_prev      <= 3'd0;
      r_step_err  <= 1'b0;
      r_err_cnt   <= 8'd0;
      r_wrap_cnt  <= 8'd0;
      r_ovf_mis   <= 1'b0;
      r_wrap_seen <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_prev      <= w_prev_nxt;
      r_step_err  <= w_step_err_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
      r_wrap_cnt  <= w_wrap_cnt_nxt;
      r_ovf_mis   <= w_ovf_mis_nxt;
      r_wrap_seen <= w_wrap_seen_nxt;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    Binary      = r_prev;
    StepErr     = r_step_err;
    ErrCount    = r_err_cnt;
    WrapCount   = r_wrap_cnt;
    OvfMismatch = r_ovf_mis;
    Locked      = (r_state == S_TRACK);
    State       = r_state;
  end

endmodule

// File: doc/gray_monitor.md
GRAY_MONITOR -- requirements
Module: gray_monitor

Interface
REQ-001 SHALL have port Clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port Valid, input, 1 bit: sample strobe; GrayIn and OverflowIn are sampled only on rising edges where Valid=1.
REQ-004 SHALL have port GrayIn, input, 3 bits: 3-bit Gray code from the upstream gray counter.
REQ-005 SHALL have port OverflowIn, input, 1 bit: sticky overflow flag from the upstream gray counter.
REQ-006 SHALL have port Binary, output, 3 bits: registered binary decode of the last sampled GrayIn.
REQ-007 SHALL have port StepErr, output, 1 bit: one-cycle pulse marking an illegal step.
REQ-008 SHALL have port ErrCount, output, 8 bits: saturating count of illegal steps.
REQ-009 SHALL have port WrapCount, output, 8 bits: modulo-256 count of 7->0 wraps.
REQ-010 SHALL have port OvfMismatch, output, 1 bit: sticky flag set when OverflowIn disagrees with observed wraps.
REQ-011 SHALL have port Locked, output, 1 bit: high when State = TRACK.
REQ-012 SHALL have port State, output, 2 bits: FSM state encoded as IDLE=00, TRACK=01, ERR=10; value 11 is unused.

Function
REQ-013 SHALL decode GrayIn to binary as follows: b2=g2, b1=g2^g1, b0=g2^g1^g0.
REQ-014 SHALL register all outputs, so each output reflects the edge at which Valid=1 was sampled, with 1-cycle latency.
REQ-015 SHALL hold all state, counters and outputs unchanged on edges where Valid=0, except StepErr, which SHALL return to 0.
REQ-016 SHALL keep prev, an internal 3-bit register that holds the last sampled binary value; Binary SHALL equal prev.
REQ-017 In IDLE, on Valid=1, SHALL load prev with the decoded value, perform no step check and no overflow check, and move to TRACK.
REQ-018 In TRACK, on Valid=1, SHALL classify the decoded value b as follows:
- hold: b==prev; no counter change.
- step: b==prev+1 (mod 8); a wrap occurs if prev==7 and b==0.
- illegal: any other value.
REQ-019 On each wrap, SHALL increment WrapCount modulo 256 (255 -> 0).
REQ-020 On an illegal value, SHALL pulse StepErr for exactly one cycle, increment ErrCount saturating at 255, and move to ERR.
REQ-021 In every classified sample, SHALL load prev with b.
REQ-022 In ERR, on Valid=1, SHALL classify b against prev using the same rules:
- hold or step: move to TRACK, counting a wrap if one occurs.
- illegal: stay in ERR, pulse StepErr and increment ErrCount.
REQ-023 In TRACK only, SHALL compute expected_ovf = (wrap seen since reset) OR (wrap on this sample).
REQ-024 In TRACK only, SHALL set OvfMismatch if OverflowIn != expected_ovf.
REQ-025 "Wrap seen since reset" SHALL be held in a dedicated sticky bit, independent of the WrapCount value, so that WrapCount rollover does not clear it.
REQ-026 SHALL perform no overflow check in IDLE or ERR.
REQ-027 SHALL clear OvfMismatch only by Reset.
REQ-028 SHALL never produce State=11; if 11 is reached, the next edge SHALL move to IDLE.

Reset
REQ-029 While Reset=1, SHALL force, asynchronously, State=IDLE, prev=0, Binary=0, StepErr=0, ErrCount=0, WrapCount=0, OvfMismatch=0, Locked=0 and the wrap-seen bit to 0.
REQ-030 On Reset deassertion mid-stream, SHALL treat the first Valid=1 sample as an IDLE capture, with no error raised.

Verification
REQ-031 The bench SHALL cover: reset, then Valid=1 with GrayIn sequence 000,001,011,010,110,111,101,100,000 and OverflowIn rising with the final 000 -> Binary ends 0, WrapCount=1, ErrCount=0, OvfMismatch=0, Locked=1.
REQ-032 The bench SHALL cover: in TRACK with prev=2 (GrayIn=011), apply GrayIn=111 (b=5) -> StepErr high for 1 cycle, ErrCount=1, State=10.
REQ-033 The bench SHALL cover: in ERR with prev=5, apply GrayIn=101 (b=6) -> State=01 with no StepErr; apply 011 (b=2) instead -> ErrCount increments, State stays 10.
REQ-034 The bench SHALL cover: OverflowIn=1 while counting 0..3 with no wrap -> OvfMismatch=1 and it stays set; then 256 wraps -> WrapCount=0 and the wrap-seen bit stays 1.
REQ-035 The bench SHALL cover: 300 consecutive illegal samples -> ErrCount holds at 255.
REQ-036 The bench SHALL cover: Valid=0 for 10 cycles with GrayIn toggling randomly -> no output changes; then assert Reset mid-cycle -> all outputs are 0 immediately, without waiting for a clock edge.
